// File: rtl/sram_read_interface.sv
// Read side of the per-SRAM packet store: walks the jump-table page chain, fetches each
// 8-word page plus its ECC code, corrects it and streams the words out with ready/valid.

module sram_ecc_decoder #(
    parameter int DW     = 128,
    parameter int CODE_W = 8
) (
    input  logic [DW-1:0]     data,
    input  logic [CODE_W-1:0] code,
    output logic [DW-1:0]     corrected,
    output logic              single_err,
    output logic              double_err
);
    localparam int POS_W = CODE_W - 1;

    // Column for data bit i is {i, parity fill} so every column has odd weight: a single
    // flip gives an odd-weight syndrome naming the bit, any double flip an even-weight one.
    logic [CODE_W-1:0] col [DW];
    logic [CODE_W-1:0] calc;
    logic [CODE_W-1:0] syndrome;

    always_comb begin
        calc = '0;
        for (int i = 0; i < DW; i++) begin
            if (data[i]) begin
                calc = calc ^ col[i];
            end
        end
    end

    assign syndrome   = calc ^ code;
    assign single_err = (syndrome != '0) && (^syndrome);
    assign double_err = (syndrome != '0) && !(^syndrome);

    for (genvar gi = 0; gi < DW; gi++) begin : g_bit
        localparam logic [POS_W-1:0] POS = POS_W'(gi);
        assign col[gi]       = {POS, ~^POS};
        assign corrected[gi] = data[gi] ^ (single_err && (syndrome[CODE_W-1:1] == POS));
    end
endmodule

module sram_read_interface #(
    parameter int SRAM_IDX    = 0,
    parameter int PAGE_ADDR_W = 11,
    parameter int DATA_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_start,
    input  logic [PAGE_ADDR_W-1:0] rd_head_addr,
    input  logic [PAGE_ADDR_W-1:0] rd_tail_addr,
    input  logic [2:0]             rd_last_len,
    output logic                   rd_busy,
    output logic                   sram_rd_en,
    output logic [PAGE_ADDR_W+2:0] sram_rd_addr,
    input  logic [DATA_W-1:0]      sram_dout,
    output logic                   jt_rd_en,
    output logic [PAGE_ADDR_W-1:0] jt_rd_addr,
    input  logic [PAGE_ADDR_W-1:0] jt_dout,
    output logic                   es_rd_en,
    output logic [PAGE_ADDR_W-1:0] es_rd_addr,
    input  logic [7:0]             es_dout,
    output logic                   out_vld,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_eop,
    input  logic                   out_rdy,
    output logic                   free_vld,
    output logic [PAGE_ADDR_W-1:0] free_addr,
    output logic                   ecc_corr,
    output logic                   ecc_fatal
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, CHECK, SEND} state_t;

    state_t                 state_reg, state_next;
    logic [PAGE_ADDR_W-1:0] cur_page_reg, tail_reg, next_page_reg, free_addr_reg;
    logic [2:0]             last_len_reg, batch_reg, word_reg;
    logic [7:0]             code_reg;
    logic                   free_vld_reg;
    logic [DATA_W-1:0]      page_buf_reg [8];

    logic [8*DATA_W-1:0]    buf_flat, corr_flat;
    logic                   dec_single, dec_double;
    logic                   on_tail, last_word, accept, cap_en;
    logic [2:0]             cap_idx;

    for (genvar gi = 0; gi < 8; gi++) begin : g_flat
        assign buf_flat[gi*DATA_W +: DATA_W] = page_buf_reg[gi];
    end

    sram_ecc_decoder #(.DW(8*DATA_W), .CODE_W(8)) u_dec (
        .data       (buf_flat),
        .code       (code_reg),
        .corrected  (corr_flat),
        .single_err (dec_single),
        .double_err (dec_double)
    );

    assign on_tail   = (cur_page_reg == tail_reg);
    assign last_word = (word_reg == 3'd7) || (on_tail && (word_reg == last_len_reg));
    assign accept    = (state_reg == SEND) && out_rdy;
    // Read data lands one cycle after its request, so the capture slot trails batch by one;
    // in WAIT batch has wrapped to 0, which makes the slot 7.
    assign cap_en    = ((state_reg == FETCH) && (batch_reg != 3'd0)) || (state_reg == WAIT);
    assign cap_idx   = batch_reg - 3'd1;

    always_comb begin
        state_next   = state_reg;
        rd_busy      = (state_reg != IDLE);
        sram_rd_en   = 1'b0;
        sram_rd_addr = '0;
        jt_rd_en     = 1'b0;
        jt_rd_addr   = '0;
        es_rd_en     = 1'b0;
        es_rd_addr   = '0;
        out_vld      = 1'b0;
        out_data     = '0;
        out_eop      = 1'b0;
        ecc_corr     = 1'b0;
        ecc_fatal    = 1'b0;
        free_vld     = free_vld_reg;
        free_addr    = free_addr_reg;
        case (state_reg)
            IDLE: begin
                if (rd_start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                sram_rd_en   = 1'b1;
                sram_rd_addr = {cur_page_reg, batch_reg};
                if (batch_reg == 3'd0) begin
                    jt_rd_en   = 1'b1;
                    jt_rd_addr = cur_page_reg;
                    es_rd_en   = 1'b1;
                    es_rd_addr = cur_page_reg;
                end
                if (batch_reg == 3'd7) begin
                    state_next = WAIT;
                end
            end
            WAIT: state_next = CHECK;
            CHECK: begin
                ecc_corr   = dec_single;
                ecc_fatal  = dec_double;
                state_next = SEND;
            end
            SEND: begin
                out_vld  = 1'b1;
                out_data = page_buf_reg[word_reg];
                out_eop  = last_word && on_tail;
                if (accept && last_word) begin
                    state_next = on_tail ? IDLE : FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cur_page_reg  <= '0;
            tail_reg      <= '0;
            next_page_reg <= '0;
            last_len_reg  <= '0;
            batch_reg     <= '0;
            word_reg      <= '0;
            code_reg      <= '0;
            free_vld_reg  <= 1'b0;
            free_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            free_vld_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rd_start) begin
                        cur_page_reg <= rd_head_addr;
                        tail_reg     <= rd_tail_addr;
                        last_len_reg <= rd_last_len;
                        batch_reg    <= '0;
                        word_reg     <= '0;
                    end
                end
                FETCH: begin
                    batch_reg <= batch_reg + 3'd1;
                    if (batch_reg == 3'd1) begin
                        next_page_reg <= jt_dout;
                        code_reg      <= es_dout;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (last_word) begin
                            word_reg      <= '0;
                            batch_reg     <= '0;
                            free_vld_reg  <= 1'b1;
                            free_addr_reg <= cur_page_reg;
                            if (!on_tail) begin
                                cur_page_reg <= next_page_reg;
                            end
                        end else begin
                            word_reg <= word_reg + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Page buffer holds raw words during fetch and is overwritten with corrected words in CHECK.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (state_reg == CHECK) begin
                page_buf_reg[k] <= corr_flat[k*DATA_W +: DATA_W];
            end else if (cap_en && (cap_idx == k[2:0])) begin
                page_buf_reg[k] <= sram_dout;
            end
        end
    end
endmodule
